dma_ctrl: RTL
=============

Name: dma_ctrl

Overview:
- Small byte-copy DMA engine between the core pipeline and mem_ctrl's read/write ports.
- Configured through four registers in the IO window (mem_ctrl io_* bus).
- When started, it stalls the core, takes over the memory ports, copies LEN bytes from SRC to DST in the current bank, then returns the ports to the core and raises a done flag/interrupt.

Parameters:
- IO_BASE, 5'h00: 5-bit IO address of SRC; DST/LEN/CTRL at IO_BASE+1..+3 (must be 4-aligned).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- io_writeaddr  in  5  IO write address from mem_ctrl
- io_writedata  in  8  IO write data
- io_write_en  in  1  IO write strobe
- io_readaddr  in  5  IO read address from mem_ctrl
- io_readdata  out  8  register readback, registered
- core_readaddr  in  8  core read address
- core_writeaddr  in  8  core write address
- core_writedata  in  8  core write data
- core_write_en  in  1  core write enable
- mem_readaddr  out  8  to mem_ctrl readaddr
- mem_writeaddr  out  8  to mem_ctrl writeaddr
- mem_writedata  out  8  to mem_ctrl writedata
- mem_write_en  out  1  to mem_ctrl write_en
- mem_readdata  in  8  from mem_ctrl readdata (1-cycle latency)
- core_stall  out  1  core holds all pipeline state while high
- irq  out  1  DONE & IE

Behaviour:
- Registers:
  - offset 0 SRC, offset 1 DST, offset 2 LEN: all 8-bit R/W.
  - offset 3 CTRL:
    - bit0 START: write 1 starts; reads as BUSY.
    - bit1 DONE: sticky; write 1 clears.
    - bit2 IE.
    - bit3 FILL: optional feature only, else reads 0.
    - bits 7:4 read 0.
- io_readdata is registered, valid the cycle after io_readaddr. Addresses outside the window read 8'h00.
- Reset: all registers 0; state IDLE; core_stall=0; irq=0; io_readdata=0. Memory ports pass through core_* combinationally.
- FSM states IDLE, READ, WRITE, RESUME.
  - IDLE:
    - mem_* = core_*; core_stall=0.
    - A write to CTRL with bit0=1 at edge T moves the FSM to READ at T+1, or to RESUME if LEN==0.
    - Same CTRL write may also set IE/clear DONE.
  - READ:
    - core_stall=1; mem_readaddr=SRC; mem_write_en=0.
    - Next state WRITE.
  - WRITE:
    - core_stall=1; mem_writeaddr=DST; mem_writedata=mem_readdata; mem_write_en=1.
    - mem_readaddr=SRC (don't-care).
    - At the edge: SRC+=1, DST+=1, LEN-=1 (8-bit wrap, FF->00).
    - Next state RESUME if the new LEN==0, else READ.
  - RESUME:
    - mem_* = core_*; core_stall=1. This lets the core's held read address re-present so readdata is valid when the stall drops.
    - DONE set on entry.
    - Next state IDLE.
- Latency: N bytes stall the core for exactly 2N+1 cycles (T+1..T+2N+1). LEN=0 stalls 1 cycle and sets DONE with no memory writes.
- Core write_en is suppressed (mem_write_en driven by DMA) in READ/WRITE and is not replayed; the core re-issues after the stall.
- IO writes while BUSY, including DMA writes landing in its own window, are ignored. START while BUSY is ignored.
- Transfers use the bank in mem_ctrl status at the time. The DMA does not touch status.
- SFR/IO addresses are not filtered: the DMA copies whatever mem_ctrl returns or accepts.
- Read-after-write on an overlapping range is correct via mem_ctrl write forwarding.
- Reset mid-transfer: next cycle IDLE, core_stall=0, registers zeroed, no further writes.
- irq = DONE & IE, combinational from registers.

Optional Feature:
- Macro DMA_FILL_EN.
- When defined, CTRL bit3 FILL is writable. With FILL=1:
  - READ is skipped: START goes to WRITE, and WRITE goes to WRITE.
  - mem_writedata=SRC; SRC does not increment.
  - N bytes take N+1 stall cycles.
- When undefined, bit3 is read-only 0 and behaviour is copy-only.

Decomposition:
- Package dma_pkg holds:
  - state encoding (IDLE/READ/WRITE/RESUME, 2 bits);
  - register offsets (0..3);
  - CTRL bit positions (START/BUSY=0, DONE=1, IE=2, FILL=3).
- One natural sub-module, dma_regs: register file, IO decode, and registered readback. The FSM and port mux stay in dma_ctrl.

Test Plan:
- Copy: SRC=10, DST=30, LEN=3, IE=1, source bytes A1 A2 A3, START → core_stall high 7 cycles; 30..32 = A1 A2 A3; SRC=13, DST=33, LEN=0; DONE=1; irq=1.
- LEN=0 START → 1 stall cycle; no mem_write_en; DONE=1. Write CTRL=8'h02 → DONE=0, irq=0.
- Wrap: SRC=FE, DST=20, LEN=3 → reads FE, FF, 00; SRC ends 01. Overlap SRC=40, DST=41, LEN=2 with 40=55 → 41=55, 42=55 (forwarding).
- Stall handshake: core holds readaddr=50 and write_en to 60 during transfer → no write to 60 while BUSY; after stall drops, readdata equals mem[50].
- Reset asserted in the second WRITE of LEN=4 → next cycle core_stall=0, all registers 0, only 1 byte written.
- DMA_FILL_EN: FILL=1, SRC=EE, DST=70, LEN=4 → 70..73=EE; 5 stall cycles. Without the macro, bit3 reads 0.

Source files
------------

// File: rtl/dma_pkg.sv
// ============================================================================
// Module : dma_pkg
// Brief  : Shared encodings for the byte-copy DMA: FSM states, register
//          offsets and CTRL bit positions.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dma_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_READ   = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;
    localparam logic [1:0] ST_RESUME = 2'd3;

    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_DONE  = 1;
    localparam int CTRL_IE    = 2;
    localparam int CTRL_FILL  = 3;

endpackage

`default_nettype wire

// File: rtl/dma_regs.sv
// ============================================================================
// Module : dma_regs
// Brief  : SRC/DST/LEN/CTRL register file, IO-window decode and registered
//          readback. FILL bit exists only when DMA_FILL_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_regs
    import dma_pkg::*;
#(
    parameter logic [4:0] IO_BASE = 5'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] io_writeaddr,
    input  logic [7:0] io_writedata,
    input  logic       io_write_en,
    input  logic [4:0] io_readaddr,
    output logic [7:0] io_readdata,
    input  logic       busy,
    input  logic       step,
    input  logic       set_done,
    output logic [7:0] src,
    output logic [7:0] dst,
    output logic [7:0] len,
    output logic       ie,
    output logic       done,
    output logic       fill,
    output logic       start,
    output logic       start_fill
);

    logic [7:0] src_q, src_d;
    logic [7:0] dst_q, dst_d;
    logic [7:0] len_q, len_d;
    logic       ie_q, ie_d;
    logic       done_q, done_d;
    logic [7:0] rdata_q, rdata_d;
    logic       w_wr;
    logic       w_rd_hit;

    // Register writes are locked out for the whole transfer, including the
    // DMA's own memory writes that might alias the IO window.
    assign w_wr     = io_write_en && !busy && (io_writeaddr[4:2] == IO_BASE[4:2]);
    assign w_rd_hit = (io_readaddr[4:2] == IO_BASE[4:2]);
    assign start    = w_wr && (io_writeaddr[1:0] == REG_CTRL) && io_writedata[CTRL_START];

`ifdef DMA_FILL_EN
    logic fill_q, fill_d;

    assign start_fill = io_writedata[CTRL_FILL];
    assign fill       = fill_q;

    always_comb begin
        fill_d = fill_q;
        if (w_wr && (io_writeaddr[1:0] == REG_CTRL)) begin
            fill_d = io_writedata[CTRL_FILL];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_q <= 1'b0;
        end else begin
            fill_q <= fill_d;
        end
    end
`else
    assign start_fill = 1'b0;
    assign fill       = 1'b0;
`endif

    always_comb begin
        src_d  = src_q;
        dst_d  = dst_q;
        len_d  = len_q;
        ie_d   = ie_q;
        done_d = done_q;
        if (step) begin
            src_d = fill ? src_q : src_q + 8'd1;
            dst_d = dst_q + 8'd1;
            len_d = len_q - 8'd1;
        end else if (w_wr) begin
            case (io_writeaddr[1:0])
                REG_SRC: src_d = io_writedata;
                REG_DST: dst_d = io_writedata;
                REG_LEN: len_d = io_writedata;
                default: begin
                    ie_d = io_writedata[CTRL_IE];
                    if (io_writedata[CTRL_DONE]) begin
                        done_d = 1'b0;
                    end
                end
            endcase
        end
        // A zero-length START clears and sets DONE on the same edge; set wins.
        if (set_done) begin
            done_d = 1'b1;
        end
    end

    always_comb begin
        rdata_d = 8'h00;
        if (w_rd_hit) begin
            case (io_readaddr[1:0])
                REG_SRC: rdata_d = src_q;
                REG_DST: rdata_d = dst_q;
                REG_LEN: rdata_d = len_q;
                default: rdata_d = {4'b0000, fill, ie_q, done_q, busy};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_q   <= 8'h00;
            dst_q   <= 8'h00;
            len_q   <= 8'h00;
            ie_q    <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            ie_q    <= ie_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    assign src         = src_q;
    assign dst         = dst_q;
    assign len         = len_q;
    assign ie          = ie_q;
    assign done        = done_q;
    assign io_readdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/dma_ctrl.sv
// ============================================================================
// Module : dma_ctrl
// Brief  : Byte-copy DMA that stalls the core and borrows mem_ctrl's ports.
//          Optional fill mode enabled by the DMA_FILL_EN macro.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_ctrl
    import dma_pkg::*;
#(
    parameter logic [4:0] IO_BASE = 5'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] io_writeaddr,
    input  logic [7:0] io_writedata,
    input  logic       io_write_en,
    input  logic [4:0] io_readaddr,
    output logic [7:0] io_readdata,
    input  logic [7:0] core_readaddr,
    input  logic [7:0] core_writeaddr,
    input  logic [7:0] core_writedata,
    input  logic       core_write_en,
    output logic [7:0] mem_readaddr,
    output logic [7:0] mem_writeaddr,
    output logic [7:0] mem_writedata,
    output logic       mem_write_en,
    input  logic [7:0] mem_readdata,
    output logic       core_stall,
    output logic       irq
);

    logic [1:0] state_q, state_d;
    logic [7:0] w_src, w_dst, w_len;
    logic       w_ie, w_done, w_fill;
    logic       w_start, w_start_fill;
    logic       w_busy, w_step, w_set_done;

    assign w_busy     = (state_q != ST_IDLE);
    assign w_step     = (state_q == ST_WRITE);
    assign w_set_done = (state_d == ST_RESUME) && (state_q != ST_RESUME);

    dma_regs #(
        .IO_BASE (IO_BASE)
    ) u_regs (
        .clk          (clk),
        .reset        (reset),
        .io_writeaddr (io_writeaddr),
        .io_writedata (io_writedata),
        .io_write_en  (io_write_en),
        .io_readaddr  (io_readaddr),
        .io_readdata  (io_readdata),
        .busy         (w_busy),
        .step         (w_step),
        .set_done     (w_set_done),
        .src          (w_src),
        .dst          (w_dst),
        .len          (w_len),
        .ie           (w_ie),
        .done         (w_done),
        .fill         (w_fill),
        .start        (w_start),
        .start_fill   (w_start_fill)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    if (w_len == 8'h00) begin
                        state_d = ST_RESUME;
                    end else if (w_start_fill) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ:  state_d = ST_WRITE;
            ST_WRITE: begin
                if (w_len == 8'h01) begin
                    state_d = ST_RESUME;
                end else if (w_fill) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_READ;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        mem_readaddr  = core_readaddr;
        mem_writeaddr = core_writeaddr;
        mem_writedata = core_writedata;
        mem_write_en  = core_write_en;
        core_stall    = 1'b0;
        case (state_q)
            ST_READ: begin
                mem_readaddr = w_src;
                mem_write_en = 1'b0;
                core_stall   = 1'b1;
            end
            ST_WRITE: begin
                mem_readaddr  = w_src;
                mem_writeaddr = w_dst;
                mem_writedata = w_fill ? w_src : mem_readdata;
                // A reset landing on a WRITE cycle must not commit that byte.
                mem_write_en  = !reset;
                core_stall    = 1'b1;
            end
            ST_RESUME: core_stall = 1'b1;
            default: ;
        endcase
    end

    assign irq = w_done & w_ie;

endmodule

`default_nettype wire
